nmea_gga_parser: RTL and testbench
==================================

# nmea_gga_parser

Byte-stream parser between the UART receive FIFO and the LCD1602 controller. It pops received bytes from the FIFO and recognises NMEA-0183 GGA sentences ($GPGGA / $GNGGA). It verifies the XOR checksum, then publishes latitude, longitude, hemispheres and fix status as space-padded ASCII registers that the LCD controller displays directly. Outputs change only on a checksum-valid sentence.

## Interface
- LAT_CHARS, 10: stored latitude characters (ddmm.mmmmm)
- LON_CHARS, 11: stored longitude characters (dddmm.mmmmm)
- MAX_LEN, 82: maximum sentence length in characters, including '$'
- clk_50MHz  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO head byte, valid whenever fifo_empty=0 (first-word-fall-through)
- fifo_rd  out  1  one-cycle pop pulse
- lat_ascii  out  8*LAT_CHARS  latitude; char 0 in MSB byte
- lat_hemi  out  8  'N'/'S'
- lon_ascii  out  8*LON_CHARS  longitude; char 0 in MSB byte
- lon_hemi  out  8  'E'/'W'
- fix_valid  out  1  1 when fix-quality field is '1'..'8'
- sentence_done  out  1  one-cycle pulse when outputs are committed
- checksum_err  out  1  one-cycle pulse when a sentence is rejected

## Operation
- Reset values: all bytes of lat_ascii, lat_hemi, lon_ascii and lon_hemi = 8'h20; fix_valid, sentence_done, checksum_err and fifo_rd = 0; FSM in IDLE.
- Read path: when fifo_empty=0 and the FSM is not in GAP, the block samples fifo_data, asserts fifo_rd for that cycle and enters GAP for one cycle. Peak throughput is one byte per 2 cycles.
- FSM states:
  - IDLE: discard bytes until '$'. On '$': clear the checksum accumulator, shadow buffers, field index and length counter, then go to HEADER.
  - HEADER: compare 5 characters against "GPGGA" or "GNGGA". On mismatch, go to IDLE with no error pulse.
  - FIELDS: each ',' increments the field index (1=time, 2=lat, 3=N/S, 4=lon, 5=E/W, 6=quality). Characters of fields 2–6 are written to shadow registers.
  - CKSUM_HI, CKSUM_LO: on '*', receive two hex characters.
  - COMMIT: compare the received checksum with the computed one and publish or reject.
- Checksum: 8-bit XOR of every character strictly between '$' and '*'. Hex digits are '0'-'9', 'A'-'F' and 'a'-'f'.
- Field buffers:
  - Left-justified; unused positions stay 8'h20.
  - Characters beyond LAT_CHARS or LON_CHARS are dropped but still XORed into the checksum.
  - Hemisphere fields keep only their first character.
- Empty fields (",,") leave spaces. An empty or '0' quality field gives fix_valid=0.
- Commit on match: copy all shadow registers to the outputs and pulse sentence_done.
- Reject on mismatch: outputs keep their previous values; pulse checksum_err.
- Abort cases:
  - '$' in any state restarts the sentence (go to HEADER, no error pulse).
  - CR or LF before '*', or a non-hex checksum character: pulse checksum_err, go to IDLE.
  - Length counter reaching MAX_LEN without '*': pulse checksum_err, go to IDLE.
- Reset mid-sentence discards the shadow state; outputs return to reset values.

## Timing
- fifo_rd is high in the same cycle the byte is consumed and is never asserted while fifo_empty=1.
- The byte after a pop is sampled no earlier than 2 cycles after the previous one.
- sentence_done or checksum_err pulses for exactly one cycle, in the cycle after the second checksum nibble is consumed.
- On commit, the outputs update on the same edge that sets sentence_done.
- sentence_done and checksum_err are never high together.
- Outputs are stable between commits, so the LCD controller samples them without a handshake.

## Structure
- Package nmea_pkg holds:
  - ASCII constants: DOLLAR, COMMA, STAR, CR, LF, SPACE.
  - The state enum: IDLE, HEADER, FIELDS, CKSUM_HI, CKSUM_LO, COMMIT, GAP.
  - Field-index constants.
  - The hex-to-nibble function.
- Sub-module nmea_field_buffer (parameter N_CHARS): clear, write-enable and char-in inputs; a space-padded, overflow-safe buffer. Instantiated for latitude and longitude.

## Test plan
- Feed "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n" -> sentence_done pulses once; lat_ascii="4807.038  ", lat_hemi='N', lon_ascii="01131.000  ", lon_hemi='E', fix_valid=1.
- Same sentence with checksum "*48" -> checksum_err pulses once; outputs remain at previous or reset values.
- Quality field '0' with a valid checksum -> sentence_done pulses; fix_valid=0.
- "$GPRMC,..." followed by a valid GGA sentence -> the RMC sentence is ignored with no pulse; the GGA sentence commits.
- '$' injected mid-field, then a full valid sentence -> no error pulse; only the second sentence commits.
- Latitude field of 14 characters with a correct checksum -> lat_ascii holds the first 10 characters and the sentence commits. Separately, assert reset during FIELDS -> all outputs return to 8'h20 or 0 within the reset cycle.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared constants, FSM state type and helpers for the NMEA GGA parser.
package nmea_pkg;

    localparam int unsigned LAT_CHARS = 10;
    localparam int unsigned LON_CHARS = 11;
    localparam int unsigned MAX_LEN   = 82;
    localparam int unsigned LEN_W     = 7;
    localparam int unsigned FLD_W     = 4;

    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] STAR   = 8'h2A;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] SPACE  = 8'h20;

    localparam logic [FLD_W-1:0] FLD_TIME = 4'd1;
    localparam logic [FLD_W-1:0] FLD_LAT  = 4'd2;
    localparam logic [FLD_W-1:0] FLD_NS   = 4'd3;
    localparam logic [FLD_W-1:0] FLD_LON  = 4'd4;
    localparam logic [FLD_W-1:0] FLD_EW   = 4'd5;
    localparam logic [FLD_W-1:0] FLD_QUAL = 4'd6;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FIELDS,
        CKSUM_HI,
        CKSUM_LO,
        COMMIT,
        GAP
    } state_e;

    // Returns {valid, nibble}; valid is 0 for anything outside 0-9, A-F, a-f.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, 4'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, 4'(c - 8'h57)};
        end
        return r;
    endfunction

endpackage

// File: rtl/nmea_field_buffer.sv
// Left-justified, space-padded character buffer; writes past N_CHARS are dropped.
module nmea_field_buffer
    import nmea_pkg::*;
#(
    parameter int unsigned N_CHARS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr,
    input  logic [7:0]           ch,
    output logic [8*N_CHARS-1:0] data
);

    localparam int unsigned PW = $clog2(N_CHARS + 1);

    logic [8*N_CHARS-1:0] chars_q, chars_d;
    logic [PW-1:0]        pos_q, pos_d;

    // Clear to spaces, or place the next character at the write position.
    always_comb begin
        chars_d = chars_q;
        pos_d   = pos_q;
        if (clr) begin
            chars_d = {N_CHARS{SPACE}};
            pos_d   = '0;
        end else if (wr && (pos_q < PW'(N_CHARS))) begin
            for (int unsigned i = 0; i < N_CHARS; i++) begin
                if (pos_q == PW'(i)) begin
                    chars_d[8*(N_CHARS-1-i) +: 8] = ch;
                end
            end
            pos_d = pos_q + PW'(1);
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chars_q <= {N_CHARS{SPACE}};
            pos_q   <= '0;
        end else begin
            chars_q <= chars_d;
            pos_q   <= pos_d;
        end
    end

    assign data = chars_q;

endmodule

// File: rtl/nmea_gga_parser.sv
// Pops UART bytes, parses GGA sentences and publishes position on a valid checksum.
module nmea_gga_parser
    import nmea_pkg::*;
(
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [7:0]             fifo_data,
    output logic                   fifo_rd,
    output logic [8*LAT_CHARS-1:0] lat_ascii,
    output logic [7:0]             lat_hemi,
    output logic [8*LON_CHARS-1:0] lon_ascii,
    output logic [7:0]             lon_hemi,
    output logic                   fix_valid,
    output logic                   sentence_done,
    output logic                   checksum_err
);

    state_e                 state_q, state_d, ret_q, ret_d;
    logic [2:0]             hdr_idx_q, hdr_idx_d;
    logic [FLD_W-1:0]       field_q, field_d;
    logic                   first_q, first_d;
    logic [7:0]             csum_q, csum_d;
    logic [3:0]             rx_hi_q, rx_hi_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [7:0]             lat_hemi_sh_q, lat_hemi_sh_d;
    logic [7:0]             lon_hemi_sh_q, lon_hemi_sh_d;
    logic [7:0]             qual_sh_q, qual_sh_d;
    logic [8*LAT_CHARS-1:0] lat_ascii_q, lat_ascii_d;
    logic [8*LON_CHARS-1:0] lon_ascii_q, lon_ascii_d;
    logic [7:0]             lat_hemi_q, lat_hemi_d, lon_hemi_q, lon_hemi_d;
    logic                   fix_valid_q, fix_valid_d;
    logic                   done_q, done_d, err_q, err_d;

    logic                   rd_c, hdr_ok_c, sh_clr_c, lat_wr_c, lon_wr_c;
    logic [4:0]             hex_c;
    logic [LEN_W-1:0]       len_inc_c;
    logic [8*LAT_CHARS-1:0] lat_sh_c;
    logic [8*LON_CHARS-1:0] lon_sh_c;

    assign rd_c      = !fifo_empty && (state_q != GAP) && (state_q != COMMIT);
    assign fifo_rd   = rd_c;
    assign hex_c     = hex_to_nibble(fifo_data);
    assign len_inc_c = len_q + LEN_W'(1);

    nmea_field_buffer #(.N_CHARS(LAT_CHARS)) u_lat_buf (
        .clk(clk_50MHz), .rst_n(reset), .clr(sh_clr_c), .wr(lat_wr_c),
        .ch(fifo_data), .data(lat_sh_c)
    );

    nmea_field_buffer #(.N_CHARS(LON_CHARS)) u_lon_buf (
        .clk(clk_50MHz), .rst_n(reset), .clr(sh_clr_c), .wr(lon_wr_c),
        .ch(fifo_data), .data(lon_sh_c)
    );

    // Header character check: "G" then "P"/"N" then "GGA".
    always_comb begin
        hdr_ok_c = 1'b0;
        case (hdr_idx_q)
            3'd0:    hdr_ok_c = (fifo_data == "G");
            3'd1:    hdr_ok_c = (fifo_data == "P") || (fifo_data == "N");
            3'd2:    hdr_ok_c = (fifo_data == "G");
            3'd3:    hdr_ok_c = (fifo_data == "G");
            3'd4:    hdr_ok_c = (fifo_data == "A");
            default: hdr_ok_c = 1'b0;
        endcase
    end

    // Next-state, shadow capture and commit logic; every consumed byte is followed by GAP or COMMIT.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        hdr_idx_d     = hdr_idx_q;
        field_d       = field_q;
        first_d       = first_q;
        csum_d        = csum_q;
        rx_hi_d       = rx_hi_q;
        len_d         = len_q;
        lat_hemi_sh_d = lat_hemi_sh_q;
        lon_hemi_sh_d = lon_hemi_sh_q;
        qual_sh_d     = qual_sh_q;
        lat_ascii_d   = lat_ascii_q;
        lon_ascii_d   = lon_ascii_q;
        lat_hemi_d    = lat_hemi_q;
        lon_hemi_d    = lon_hemi_q;
        fix_valid_d   = fix_valid_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        sh_clr_c      = 1'b0;
        lat_wr_c      = 1'b0;
        lon_wr_c      = 1'b0;

        case (state_q)
            GAP:    state_d = ret_q;
            COMMIT: state_d = IDLE;
            default: begin
                if (rd_c) begin
                    state_d = GAP;
                    ret_d   = state_q;
                    if (fifo_data == DOLLAR) begin
                        csum_d        = 8'd0;
                        sh_clr_c      = 1'b1;
                        field_d       = '0;
                        first_d       = 1'b0;
                        len_d         = LEN_W'(1);
                        hdr_idx_d     = 3'd0;
                        lat_hemi_sh_d = SPACE;
                        lon_hemi_sh_d = SPACE;
                        qual_sh_d     = SPACE;
                        ret_d         = HEADER;
                    end else begin
                        case (state_q)
                            HEADER: begin
                                csum_d = csum_q ^ fifo_data;
                                len_d  = len_inc_c;
                                if (hdr_ok_c) begin
                                    hdr_idx_d = hdr_idx_q + 3'd1;
                                    if (hdr_idx_q == 3'd4) ret_d = FIELDS;
                                end else begin
                                    ret_d = IDLE;
                                end
                            end
                            FIELDS: begin
                                if (fifo_data == STAR) begin
                                    ret_d = CKSUM_HI;
                                end else if (fifo_data == CR || fifo_data == LF) begin
                                    err_d = 1'b1;
                                    ret_d = IDLE;
                                end else begin
                                    csum_d = csum_q ^ fifo_data;
                                    len_d  = len_inc_c;
                                    if (len_inc_c >= LEN_W'(MAX_LEN)) begin
                                        err_d = 1'b1;
                                        ret_d = IDLE;
                                    end else if (fifo_data == COMMA) begin
                                        if (field_q != '1) field_d = field_q + FLD_W'(1);
                                        first_d = 1'b1;
                                    end else begin
                                        first_d = 1'b0;
                                        case (field_q)
                                            FLD_LAT:  lat_wr_c = 1'b1;
                                            FLD_NS:   if (first_q) lat_hemi_sh_d = fifo_data;
                                            FLD_LON:  lon_wr_c = 1'b1;
                                            FLD_EW:   if (first_q) lon_hemi_sh_d = fifo_data;
                                            FLD_QUAL: if (first_q) qual_sh_d = fifo_data;
                                            default:  ;
                                        endcase
                                    end
                                end
                            end
                            CKSUM_HI: begin
                                if (hex_c[4]) begin
                                    rx_hi_d = hex_c[3:0];
                                    ret_d   = CKSUM_LO;
                                end else begin
                                    err_d = 1'b1;
                                    ret_d = IDLE;
                                end
                            end
                            CKSUM_LO: begin
                                state_d = COMMIT;
                                if (hex_c[4] && ({rx_hi_q, hex_c[3:0]} == csum_q)) begin
                                    done_d      = 1'b1;
                                    lat_ascii_d = lat_sh_c;
                                    lon_ascii_d = lon_sh_c;
                                    lat_hemi_d  = lat_hemi_sh_q;
                                    lon_hemi_d  = lon_hemi_sh_q;
                                    fix_valid_d = (qual_sh_q >= "1") && (qual_sh_q <= "8");
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: ret_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // State, shadow and output registers.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ret_q         <= IDLE;
            hdr_idx_q     <= 3'd0;
            field_q       <= '0;
            first_q       <= 1'b0;
            csum_q        <= 8'd0;
            rx_hi_q       <= 4'd0;
            len_q         <= '0;
            lat_hemi_sh_q <= SPACE;
            lon_hemi_sh_q <= SPACE;
            qual_sh_q     <= SPACE;
            lat_ascii_q   <= {LAT_CHARS{SPACE}};
            lon_ascii_q   <= {LON_CHARS{SPACE}};
            lat_hemi_q    <= SPACE;
            lon_hemi_q    <= SPACE;
            fix_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            hdr_idx_q     <= hdr_idx_d;
            field_q       <= field_d;
            first_q       <= first_d;
            csum_q        <= csum_d;
            rx_hi_q       <= rx_hi_d;
            len_q         <= len_d;
            lat_hemi_sh_q <= lat_hemi_sh_d;
            lon_hemi_sh_q <= lon_hemi_sh_d;
            qual_sh_q     <= qual_sh_d;
            lat_ascii_q   <= lat_ascii_d;
            lon_ascii_q   <= lon_ascii_d;
            lat_hemi_q    <= lat_hemi_d;
            lon_hemi_q    <= lon_hemi_d;
            fix_valid_q   <= fix_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign lat_ascii     = lat_ascii_q;
    assign lon_ascii     = lon_ascii_q;
    assign lat_hemi      = lat_hemi_q;
    assign lon_hemi      = lon_hemi_q;
    assign fix_valid     = fix_valid_q;
    assign sentence_done = done_q;
    assign checksum_err  = err_q;

endmodule

// File: tb/tb_nmea_gga_parser.sv
// Directed bench for nmea_gga_parser: feeds ASCII sentences through a FWFT FIFO model.
module tb_nmea_gga_parser;
    import nmea_pkg::*;

    logic                   clk_50MHz = 1'b0;
    logic                   reset;
    logic                   fifo_empty;
    logic [7:0]             fifo_data;
    logic                   fifo_rd;
    logic [8*LAT_CHARS-1:0] lat_ascii;
    logic [7:0]             lat_hemi;
    logic [8*LON_CHARS-1:0] lon_ascii;
    logic [7:0]             lon_hemi;
    logic                   fix_valid;
    logic                   sentence_done;
    logic                   checksum_err;

    int n_vec = 0, n_err = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, bad_rd_cnt = 0;
    int d0, e0;
    string s;

    nmea_gga_parser dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .lat_ascii(lat_ascii),
        .lat_hemi(lat_hemi), .lon_ascii(lon_ascii), .lon_hemi(lon_hemi),
        .fix_valid(fix_valid), .sentence_done(sentence_done),
        .checksum_err(checksum_err)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // Pulse and protocol monitor sampled on the inactive edge.
    always @(negedge clk_50MHz) begin
        if (sentence_done) done_cnt++;
        if (checksum_err) err_cnt++;
        if (sentence_done && checksum_err) both_cnt++;
        if (fifo_rd && fifo_empty) bad_rd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [87:0] act, input logic [87:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one byte and hold it until the DUT pops it; returns just after the pop edge.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        fifo_data  = b;
        fifo_empty = 1'b0;
        #1;
        while (!fifo_rd && n < 8) begin
            @(negedge clk_50MHz);
            #1;
            n++;
        end
        if (!fifo_rd) check_eq("pop_timeout", 88'(fifo_rd), 88'd1);
        @(negedge clk_50MHz);
        fifo_empty = 1'b1;
    endtask

    task automatic push_str(input string str);
        for (int i = 0; i < str.len(); i++) push_byte(str[i]);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_50MHz);
    endtask

    function automatic string with_cksum(input string body, input bit lower);
        logic [7:0] x = 8'd0;
        for (int i = 1; i < body.len(); i++) x = x ^ body[i];
        return {body, "*", lower ? $sformatf("%02x", x) : $sformatf("%02X", x), "\r\n"};
    endfunction

    task automatic check_pulses(input string tag, input int de, input int ee);
        check_eq({tag, "_done_cnt"}, 88'(done_cnt - d0), 88'(de));
        check_eq({tag, "_err_cnt"}, 88'(err_cnt - e0), 88'(ee));
    endtask

    task automatic mark();
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        repeat (2) @(negedge clk_50MHz);
        check_eq("rst_lat", 88'(lat_ascii), 88'({LAT_CHARS{8'h20}}));
        check_eq("rst_lon", 88'(lon_ascii), 88'({LON_CHARS{8'h20}}));
        check_eq("rst_hemi", 88'({lat_hemi, lon_hemi}), 88'(16'h2020));
        check_eq("rst_flags", 88'({fix_valid, sentence_done, checksum_err, fifo_rd}), 88'd0);
        reset = 1'b1;
        @(negedge clk_50MHz);

        // Reference sentence; commit lands on the edge of the last checksum nibble.
        mark();
        push_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47");
        check_eq("t1_done_now", 88'(sentence_done), 88'd1);
        check_eq("t1_lat_now", 88'(lat_ascii), 88'("4807.038  "));
        push_str("\r\n");
        settle();
        check_pulses("t1", 1, 0);
        check_eq("t1_lon", 88'(lon_ascii), 88'("01131.000  "));
        check_eq("t1_hemi", 88'({lat_hemi, lon_hemi}), 88'("NE"));
        check_eq("t1_fix", 88'(fix_valid), 88'd1);

        // Bad checksum: reject, outputs held.
        mark();
        push_str("$GPGGA,123519,9999.999,S,01131.000,W,0,08,0.9,545.4,M,46.9,M,,*48\r\n");
        settle();
        check_pulses("t2", 0, 1);
        check_eq("t2_lat", 88'(lat_ascii), 88'("4807.038  "));
        check_eq("t2_hemi", 88'({lat_hemi, lon_hemi}), 88'("NE"));
        check_eq("t2_fix", 88'(fix_valid), 88'd1);

        // Quality 0, GNGGA, lowercase checksum digits.
        mark();
        push_str(with_cksum("$GNGGA,010203,3412.5,S,11830.25,W,0,00,,,M,,M,,", 1'b1));
        settle();
        check_pulses("t3", 1, 0);
        check_eq("t3_lat", 88'(lat_ascii), 88'("3412.5    "));
        check_eq("t3_lon", 88'(lon_ascii), 88'("11830.25   "));
        check_eq("t3_hemi", 88'({lat_hemi, lon_hemi}), 88'("SW"));
        check_eq("t3_fix", 88'(fix_valid), 88'd0);

        // RMC ignored, following GGA commits.
        mark();
        push_str("$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n");
        push_str(with_cksum("$GPGGA,000001,1111.11111,N,02222.22222,E,2,05,1.0,10.0,M,0.0,M,,", 1'b0));
        settle();
        check_pulses("t4", 1, 0);
        check_eq("t4_lat", 88'(lat_ascii), 88'("1111.11111"));
        check_eq("t4_lon", 88'(lon_ascii), 88'("02222.22222"));
        check_eq("t4_fix", 88'(fix_valid), 88'd1);

        // '$' mid-field restarts silently.
        mark();
        push_str("$GPGGA,1234,56");
        push_str(with_cksum("$GPGGA,5,5555.5,S,00005.5,E,6,", 1'b0));
        settle();
        check_pulses("t5", 1, 0);
        check_eq("t5_lat", 88'(lat_ascii), 88'("5555.5    "));
        check_eq("t5_lon", 88'(lon_ascii), 88'("00005.5    "));
        check_eq("t5_hemi", 88'({lat_hemi, lon_hemi}), 88'("SE"));

        // 14-character latitude truncates to 10 but still checksums.
        mark();
        push_str(with_cksum("$GPGGA,1,12345678901234,N,1,E,3,", 1'b0));
        settle();
        check_pulses("t6", 1, 0);
        check_eq("t6_lat", 88'(lat_ascii), 88'("1234567890"));
        check_eq("t6_lon", 88'(lon_ascii), 88'("1          "));

        // CR before '*' aborts with error.
        mark();
        push_str("$GPGGA,1,2\r\n");
        settle();
        check_pulses("t7", 0, 1);
        check_eq("t7_lat", 88'(lat_ascii), 88'("1234567890"));

        // Non-hex checksum character.
        mark();
        push_str("$GPGGA,1,2*G1\r\n");
        settle();
        check_pulses("t8", 0, 1);

        // Overlong sentence without '*'.
        mark();
        s = "$GPGGA";
        for (int i = 0; i < 80; i++) s = {s, ","};
        push_str(s);
        settle();
        check_pulses("t9", 0, 1);
        check_eq("t9_lat", 88'(lat_ascii), 88'("1234567890"));

        // Reset mid-field returns outputs to reset values, then a clean sentence commits.
        push_str("$GPGGA,1,99");
        reset = 1'b0;
        #1;
        check_eq("t10_lat", 88'(lat_ascii), 88'({LAT_CHARS{8'h20}}));
        check_eq("t10_lon", 88'(lon_ascii), 88'({LON_CHARS{8'h20}}));
        check_eq("t10_hemi", 88'({lat_hemi, lon_hemi}), 88'(16'h2020));
        check_eq("t10_flags", 88'({fix_valid, sentence_done, checksum_err}), 88'd0);
        @(negedge clk_50MHz);
        reset = 1'b1;
        @(negedge clk_50MHz);
        mark();
        push_str(with_cksum("$GPGGA,2,4000.0,N,00100.0,W,1,", 1'b0));
        settle();
        check_pulses("t11", 1, 0);
        check_eq("t11_lat", 88'(lat_ascii), 88'("4000.0    "));
        check_eq("t11_hemi", 88'({lat_hemi, lon_hemi}), 88'("NW"));

        check_eq("both_pulses", 88'(both_cnt), 88'd0);
        check_eq("rd_while_empty", 88'(bad_rd_cnt), 88'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
